player_bullet_manager: RTL

Owns the player-bullet pool for the shooter: allocates a slot when the player fires, advances every live bullet once per frame, retires bullets that leave the top of the screen, and removes bullets destroyed by the collision stage. It produces the player-bullet state and position arrays that the collision stage consumes. Each frame it consumes the collision stage's post-collision bullet state.

---
 rtl/game_pkg.sv | 39 +++
 rtl/player_bullet_manager_if.sv | 30 +++
 rtl/player_bullet_slot_finder.sv | 25 ++
 rtl/player_bullet_manager.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared shooter definitions: slot count, position field layout, sprite sizes,
// the bullet-manager FSM states and the spawn X helper.
package game_pkg;

   localparam int MAX_PLAYER_BULLET = 15;
   localparam int SLOT_IDX_W        = $clog2(MAX_PLAYER_BULLET);

   localparam int POS_W = 19;
   localparam int X_MSB = 18;
   localparam int X_LSB = 9;
   localparam int Y_MSB = 8;
   localparam int Y_LSB = 0;

   localparam logic [POS_W-1:0] NONE = {POS_W{1'b1}};

   localparam logic [8:0] PLAYER_Y      = 9'd440;
   localparam logic [9:0] PLAYER_WIDTH  = 10'd24;
   localparam logic [9:0] BULLET_WIDTH  = 10'd4;
   localparam logic [8:0] BULLET_HEIGHT = 9'd16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MERGE = 3'd1,
      S_MOVE  = 3'd2,
      S_SPAWN = 3'd3,
      S_DONE  = 3'd4
   } pb_state_e;

   // Centre the bullet on the player; the 11-bit sum keeps the carry so a
   // player near the right edge clamps instead of wrapping to the left.
   function automatic logic [9:0] spawn_x(input logic [9:0] player_x);
      logic [10:0] sum;
      logic [10:0] x_max;
      sum   = {1'b0, player_x} + 11'((PLAYER_WIDTH - BULLET_WIDTH) >> 1);
      x_max = {1'b0, 10'd1023 - BULLET_WIDTH};
      return (sum > x_max) ? x_max[9:0] : sum[9:0];
   endfunction

endpackage

// File: rtl/player_bullet_manager_if.sv
// Bundle of the bullet manager's frame/fire inputs and pool outputs.
// master = bullet manager side, slave = game/collision side.
interface player_bullet_manager_if;
   import game_pkg::*;

   logic                               frame_tick;
   logic                               fire;
   logic                               player_state;
   logic [9:0]                         player_position;
   logic [MAX_PLAYER_BULLET-1:0]       collision_state;
   logic [MAX_PLAYER_BULLET-1:0]       bullet_state;
   logic [MAX_PLAYER_BULLET*POS_W-1:0] bullet_position;
   logic                               busy;
   logic                               update_done;
   logic                               fire_accepted;
   logic                               fire_dropped;

   // Outputs are only meaningful to the slave while busy is low; update_done
   // and the fire pulses are single-cycle strobes with no back-pressure.
   modport master (
      input  frame_tick, fire, player_state, player_position, collision_state,
      output bullet_state, bullet_position, busy, update_done, fire_accepted, fire_dropped
   );

   modport slave (
      output frame_tick, fire, player_state, player_position, collision_state,
      input  bullet_state, bullet_position, busy, update_done, fire_accepted, fire_dropped
   );

endinterface

// File: rtl/player_bullet_slot_finder.sv
// Combinational priority encoder: lowest-index free (state=0) bullet slot.
module player_bullet_slot_finder
   import game_pkg::*;
#(
   parameter int N     = MAX_PLAYER_BULLET,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_slot_state,
   output logic [IDX_W-1:0] o_free_idx,
   output logic             o_found
);

   // Scan downward so the lowest free index is the last one written.
   always_comb begin
      o_free_idx = '0;
      o_found    = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!i_slot_state[i]) begin
            o_free_idx = IDX_W'(i);
            o_found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/player_bullet_manager.sv
// Player-bullet pool: per-frame merge of collision results, move/retire, spawn.
// Build option PLAYER_BULLET_AUTOFIRE_EN: fire latch follows i_Fire level.
module player_bullet_manager
   import game_pkg::*;
#(
   parameter logic [8:0] BULLET_SPEED  = 9'd4,
   parameter logic [3:0] FIRE_COOLDOWN = 4'd8
) (
   input  logic                               i_Clk,
   input  logic                               i_Rst_n,
   input  logic                               i_FrameTick,
   input  logic                               i_Fire,
   input  logic                               i_PlayerState,
   input  logic [9:0]                         i_PlayerPosition,
   input  logic [MAX_PLAYER_BULLET-1:0]       i_CollisionState,
   output logic [MAX_PLAYER_BULLET-1:0]       o_PlayerBulletState,
   output logic [MAX_PLAYER_BULLET*POS_W-1:0] o_PlayerBulletPosition,
   output logic                               o_Busy,
   output logic                               o_UpdateDone,
   output logic                               o_FireAccepted,
   output logic                               o_FireDropped,
   output logic [2:0]                         o_DbgState
);

   localparam logic [SLOT_IDX_W-1:0] LAST_IDX = SLOT_IDX_W'(MAX_PLAYER_BULLET - 1);
   localparam logic [Y_MSB-Y_LSB:0]  SPAWN_Y  = PLAYER_Y - BULLET_HEIGHT;

   pb_state_e                    state_q, state_d;
   logic [SLOT_IDX_W-1:0]        idx_q, idx_d;
   logic [MAX_PLAYER_BULLET-1:0] bstate_q, bstate_d;
   logic [POS_W-1:0]             pos_q [MAX_PLAYER_BULLET];
   logic [POS_W-1:0]             pos_d [MAX_PLAYER_BULLET];
   logic [3:0]                   cool_q, cool_d;
   logic                         latch_q, latch_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;
   logic                         acc_q, acc_d;
   logic                         drop_q, drop_d;
   logic                         fire_set;
   logic [SLOT_IDX_W-1:0]        free_idx;
   logic                         free_found;

`ifdef PLAYER_BULLET_AUTOFIRE_EN
   assign fire_set = i_Fire;
`else
   logic fire_prev_q, fire_prev_d;
   assign fire_prev_d = i_Fire;
   assign fire_set    = i_Fire & ~fire_prev_q;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) fire_prev_q <= 1'b0;
      else          fire_prev_q <= fire_prev_d;
   end
`endif

   // Sees the pool after MERGE/MOVE, so slots freed this frame are reusable.
   player_bullet_slot_finder #(
      .N     (MAX_PLAYER_BULLET),
      .IDX_W (SLOT_IDX_W)
   ) u_slot_finder (
      .i_slot_state (bstate_q),
      .o_free_idx   (free_idx),
      .o_found      (free_found)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      bstate_d = bstate_q;
      pos_d    = pos_q;
      cool_d   = cool_q;
      latch_d  = latch_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      acc_d    = 1'b0;
      drop_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_FrameTick) begin
               state_d = S_MERGE;
               busy_d  = 1'b1;
            end
         end
         S_MERGE: begin
            for (int i = 0; i < MAX_PLAYER_BULLET; i++) begin
               if (bstate_q[i] && !i_CollisionState[i]) begin
                  bstate_d[i] = 1'b0;
                  pos_d[i]    = NONE;
               end
            end
            idx_d   = '0;
            state_d = S_MOVE;
         end
         S_MOVE: begin
            if (bstate_q[idx_q]) begin
               if (pos_q[idx_q][Y_MSB:Y_LSB] < BULLET_SPEED) begin
                  bstate_d[idx_q] = 1'b0;
                  pos_d[idx_q]    = NONE;
               end else begin
                  pos_d[idx_q][Y_MSB:Y_LSB] = pos_q[idx_q][Y_MSB:Y_LSB] - BULLET_SPEED;
               end
            end
            if (idx_q == LAST_IDX) state_d = S_SPAWN;
            else                   idx_d   = idx_q + 1'b1;
         end
         S_SPAWN: begin
            latch_d = 1'b0;
            if (cool_q != 4'd0) begin
               cool_d = cool_q - 4'd1;
            end else if (latch_q && i_PlayerState) begin
               if (free_found) begin
                  bstate_d[free_idx]             = 1'b1;
                  pos_d[free_idx][X_MSB:X_LSB]   = spawn_x(i_PlayerPosition);
                  pos_d[free_idx][Y_MSB:Y_LSB]   = SPAWN_Y;
                  cool_d                         = FIRE_COOLDOWN;
                  acc_d                          = 1'b1;
               end else begin
                  drop_d = 1'b1;
               end
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      // A press in any state, including the SPAWN cycle itself, stays latched.
      if (fire_set) latch_d = 1'b1;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         bstate_q <= '0;
         for (int i = 0; i < MAX_PLAYER_BULLET; i++) pos_q[i] <= NONE;
         cool_q   <= '0;
         latch_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         acc_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         bstate_q <= bstate_d;
         pos_q    <= pos_d;
         cool_q   <= cool_d;
         latch_q  <= latch_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         acc_q    <= acc_d;
         drop_q   <= drop_d;
      end
   end

   for (genvar g = 0; g < MAX_PLAYER_BULLET; g++) begin : g_pos_out
      assign o_PlayerBulletPosition[g*POS_W +: POS_W] = pos_q[g];
   end

   assign o_PlayerBulletState = bstate_q;
   assign o_Busy              = busy_q;
   assign o_UpdateDone        = done_q;
   assign o_FireAccepted      = acc_q;
   assign o_FireDropped       = drop_q;
   assign o_DbgState          = state_q;

endmodule
